// File: rtl/pipe_seq_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller and its helpers.
package pipe_seq_ctrl_pkg;

  localparam int unsigned REG_W = 4;
  localparam logic [REG_W-1:0] REG_ZERO = 4'h0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_t;

endpackage

// File: rtl/pipe_seq_ctrl_lu_hazard.sv
// Load-use hazard compare: a load in EX writes a register the ID instruction reads.
module lu_hazard
  import pipe_seq_ctrl_pkg::*;
(
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             hazard_c
);

  // r0 is hardwired to zero, so a load targeting it can never feed a consumer
  assign hazard_c = ex_memread && (ex_rd != REG_ZERO) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller: register enables, flushes and bubbles for the
// 5-stage core covering load-use, branch squash, memory waits and HALT drain.
module pipe_seq_ctrl
  import pipe_seq_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_halt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic             m_mem_en,
  input  logic             m_mem_ready,
  input  logic             wb_halt,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             idex_wen,
  output logic             exm_wen,
  output logic             mwb_wen,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mwb_bubble,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  state_t              state, state_n;
  state_t              ret_state, ret_state_n;
  state_t              base_c;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_n;
  logic                mem_err_n;
  logic                load_use_c;
  logic                mem_stall_c;
  logic                advance_c;

  lu_hazard u_lu_hazard (
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .hazard_c   (load_use_c)
  );

  assign mem_stall_c = m_mem_en && !m_mem_ready;

  // Next state and same-cycle pipeline controls
  always_comb begin
    pc_wen      = 1'b1;
    ifid_wen    = 1'b1;
    idex_wen    = 1'b1;
    exm_wen     = 1'b1;
    mwb_wen     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    mwb_bubble  = 1'b0;
    state_n     = state;
    ret_state_n = ret_state;
    wait_cnt_n  = wait_cnt;
    mem_err_n   = mem_err;
    advance_c   = 1'b0;
    base_c      = state;

    case (state)
      RUN, DRAIN: advance_c = 1'b1;
      MEM_WAIT: begin
        if (!m_mem_ready) begin
          pc_wen     = 1'b0;
          ifid_wen   = 1'b0;
          idex_wen   = 1'b0;
          exm_wen    = 1'b0;
          mwb_bubble = 1'b1;
          wait_cnt_n = wait_cnt + WAIT_W'(1);
          if (wait_cnt_n >= WAIT_LIMIT) begin
            state_n   = HALTED;
            mem_err_n = 1'b1;
          end
        end else begin
          // memory completed: advance under the rules of the interrupted state
          advance_c  = 1'b1;
          base_c     = ret_state;
          state_n    = ret_state;
          wait_cnt_n = '0;
        end
      end
      default: begin
        pc_wen   = 1'b0;
        ifid_wen = 1'b0;
        idex_wen = 1'b0;
        exm_wen  = 1'b0;
        mwb_wen  = 1'b0;
      end
    endcase

    if (advance_c) begin
      if (base_c == DRAIN) begin
        pc_wen     = 1'b0;
        ifid_flush = 1'b1;
      end
      if (mem_stall_c) begin
        pc_wen      = 1'b0;
        ifid_wen    = 1'b0;
        idex_wen    = 1'b0;
        exm_wen     = 1'b0;
        ifid_flush  = 1'b0;
        mwb_bubble  = 1'b1;
        ret_state_n = base_c;
        state_n     = MEM_WAIT;
        wait_cnt_n  = WAIT_W'(1);
        if (wait_cnt_n >= WAIT_LIMIT) begin
          state_n   = HALTED;
          mem_err_n = 1'b1;
        end
      end else if (ex_branch_taken) begin
        pc_wen     = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use_c) begin
        pc_wen     = 1'b0;
        ifid_wen   = 1'b0;
        idex_flush = 1'b1;
      end else if (id_halt && (base_c == RUN)) begin
        state_n = DRAIN;
      end
    end

    if (wb_halt && (state != HALTED)) state_n = HALTED;
  end

  // State, watchdog, sticky flags and stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      ret_state <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      halted    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_n;
      ret_state <= ret_state_n;
      wait_cnt  <= wait_cnt_n;
      mem_err   <= mem_err_n;
      halted    <= (state_n == HALTED);
      if (((state == RUN) || (state == MEM_WAIT)) && !pc_wen && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_seq_ctrl.md
# pipe_seq_ctrl

Pipeline sequencing controller for the 5-stage core. It generates write-enable and flush/bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It handles load-use stalls, taken-branch squashes, variable-latency data-memory waits with a watchdog, and HALT drain. It sits beside the datapath, drives only register enables and flushes, and never touches data.

## Interface
Parameters:
- MAX_WAIT, default 15: maximum consecutive memory-wait cycles before fault (1..255).
- CNT_W, default 16: stall performance counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_rs, id_rt  in  4  source registers of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt.
- id_halt  in  1  HALT decoded in ID.
- ex_memread  in  1  EX instruction is a load.
- ex_rd  in  4  EX destination register.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- m_mem_en  in  1  MEM stage accessing data memory.
- m_mem_ready  in  1  data memory completes this cycle.
- wb_halt  in  1  HALT control bit at WB.
- pc_wen, ifid_wen, idex_wen, exm_wen, mwb_wen  out  1  register enables.
- ifid_flush, idex_flush  out  1  load bubble (control bits zero) on the next edge.
- mwb_bubble  out  1  MEM/WB captures zeroed control (no RegWrite/HALT).
- halted  out  1  core stopped (registered).
- mem_err  out  1  sticky watchdog fault (registered).
- stall_cnt  out  CNT_W  saturating stall-cycle count.

## Operation
- State machine: RUN, MEM_WAIT, DRAIN, HALTED.
- Enable and flush outputs are combinational from state and inputs. Default in RUN: all wen=1, flushes=0, mwb_bubble=0.
- Event priority within RUN and DRAIN: memory stall, then branch squash, then load-use, then halt.
- Memory stall (m_mem_en & !m_mem_ready, RUN or DRAIN):
  - pc/ifid/idex/exm wen=0.
  - mwb_wen=1 with mwb_bubble=1, so WB never writes twice.
  - Go to MEM_WAIT and record the return state (RUN or DRAIN).
- MEM_WAIT: same freeze while !m_mem_ready.
  - On m_mem_ready: normal advance that cycle, return to the saved state, wait counter cleared.
  - Wait counter increments each frozen cycle. On reaching MAX_WAIT: mem_err←1 and go to HALTED.
- Branch squash (ex_branch_taken): ifid_flush=1, idex_flush=1, pc_wen=1. Any id_halt or load-use in the same cycle is ignored.
- Load-use hazard: ex_memread & ex_rd≠0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
  - Effect: pc_wen=0, ifid_wen=0, idex_flush=1 for exactly one cycle.
  - Register 0 never creates a hazard.
- Halt: id_halt in RUN (no squash, no stall) → DRAIN.
- DRAIN: pc_wen=0, ifid_flush=1 each cycle; downstream stages advance normally.
- wb_halt in any state other than HALTED → HALTED next edge.
- HALTED: all wen=0, flushes=0. Absorbing until rst_n.
- stall_cnt counts each cycle with pc_wen=0 in RUN or MEM_WAIT. It saturates at all-ones and never counts in DRAIN or HALTED.

## Timing
- Reset values: state RUN, halted=0, mem_err=0, stall_cnt=0, wait counter 0, saved state RUN.
- Right after reset with idle inputs: all wen=1, flushes=0, mwb_bubble=0.
- Stall/squash controls take effect the same cycle (zero latency). halted and mem_err assert one edge after the trigger.
- A MEM_WAIT ending with m_mem_ready in the same cycle as it was entered is impossible; the entry condition requires !m_mem_ready.
- rst_n assertion mid-wait or mid-drain clears everything immediately (asynchronous). Release is synchronous to clk.

## Structure
- Shared package holds:
  - the state enum (RUN, MEM_WAIT, DRAIN, HALTED);
  - the REG_ZERO constant 4'h0;
  - the register-index width constant.
- Sub-module lu_hazard: purely combinational load-use compare producing one bit. It is reused by the forwarding unit.
- Remaining logic (FSM, wait counter, stall counter) is flat in pipe_seq_ctrl.

## Test plan
- Load r3, then add reading r3 in ID (ex_memread=1, ex_rd=3, id_rs=3) → one cycle with pc_wen=0, ifid_wen=0, idex_flush=1; stall_cnt=1.
- Same load with ex_rd=0 and id_rs=0 → no stall; all wen=1.
- m_mem_en=1, m_mem_ready low for 3 cycles then high → 3 frozen cycles with mwb_bubble=1, advance on the 4th; stall_cnt=3.
- m_mem_ready held low with MAX_WAIT=4 → mem_err=1 and halted=1 after the 4th wait cycle; all wen=0 thereafter.
- id_halt at cycle t → DRAIN from t+1 with pc_wen=0 and ifid_flush=1; wb_halt at t+3 → halted=1 at t+4.
- ex_branch_taken and id_halt in the same cycle → ifid_flush=1, idex_flush=1, state remains RUN.
